drop_timer: RTL and testbench

- Gravity timer for the 8x8 LED Tetris game.
- Keeps a free-running cycle counter and a line-clear counter. Both are built on the team's `increment` stage, which computes `in+1` combinationally.
- Emits a one-cycle `tick` that tells the game FSM to drop the active piece one row.
- The tick period shortens as `level` rises, and a fixed fast period applies while soft-drop is held.

---
 rtl/drop_timer.sv | 114 +++++++++++
 tb/tb_drop_timer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/drop_timer.sv
// Gravity timer for the 8x8 LED Tetris game.
// A free-running cycle counter issues a one-cycle drop strobe whose period
// shrinks with the level. A line-clear counter advances that level.

// Combinational +1 stage shared by every counter in this block.
module increment #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);

    assign out = in + W'(1);

endmodule

module drop_timer #(
    parameter int unsigned WIDTH           = 25,
    parameter int unsigned BASE_PERIOD     = 25000000,
    parameter int unsigned MIN_PERIOD      = 3125000,
    parameter int unsigned FAST_PERIOD     = 2500000,
    parameter int unsigned LINES_PER_LEVEL = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pause,
    input  logic       restart,
    input  logic       soft_drop,
    input  logic       line_clr,
    output logic       tick,
    output logic [2:0] level
);

    localparam logic [WIDTH-1:0] BASE_W   = WIDTH'(BASE_PERIOD);
    localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(MIN_PERIOD);
    localparam logic [WIDTH-1:0] FAST_W   = WIDTH'(FAST_PERIOD);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [3:0]       LINES_TC = 4'(LINES_PER_LEVEL - 1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [3:0]       lines;
    logic [3:0]       lines_next;
    logic [2:0]       level_next;
    logic [WIDTH-1:0] lvl_p;
    logic [WIDTH-1:0] per;
    logic             term;

    increment #(.W(WIDTH)) u_cnt_inc (
        .in  (cnt),
        .out (cnt_next)
    );

    increment #(.W(4)) u_lines_inc (
        .in  (lines),
        .out (lines_next)
    );

    increment #(.W(3)) u_level_inc (
        .in  (level),
        .out (level_next)
    );

    // Period select. The >= compare lets a shortened period take effect on
    // the next edge instead of letting the counter run up and wrap.
    always_comb begin
        lvl_p = BASE_W >> level;
        if (soft_drop) begin
            per = FAST_W;
        end else if (lvl_p < MIN_W) begin
            per = MIN_W;
        end else begin
            per = lvl_p;
        end
        term = (cnt >= (per - ONE_W));
    end

    // Cycle counter and drop strobe: restart beats pause beats counting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (restart) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (pause) begin
            tick <= 1'b0;
        end else if (term) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt_next;
            tick <= 1'b0;
        end
    end

    // Line and level counters; level saturates at 7 while lines keeps wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lines <= '0;
            level <= '0;
        end else if (line_clr) begin
            if (lines == LINES_TC) begin
                lines <= '0;
                if (level != 3'd7) begin
                    level <= level_next;
                end
            end else begin
                lines <= lines_next;
            end
        end
    end

endmodule

// File: tb/tb_drop_timer.sv
// Self-checking bench for drop_timer with a short-period parameter set.
module tb_drop_timer;

    logic       clk;
    logic       reset;
    logic       pause;
    logic       restart;
    logic       soft_drop;
    logic       line_clr;
    logic       tick;
    logic [2:0] level;

    int checks   = 0;
    int failures = 0;

    drop_timer #(
        .WIDTH           (8),
        .BASE_PERIOD     (16),
        .MIN_PERIOD      (4),
        .FAST_PERIOD     (2),
        .LINES_PER_LEVEL (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pause     (pause),
        .restart   (restart),
        .soft_drop (soft_drop),
        .line_clr  (line_clr),
        .tick      (tick),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One segment: inputs held constant for ncyc edges, then the number of
    // tick-high samples seen, the final tick value and the final level.
    typedef struct {
        logic rst_n;
        logic pz;
        logic rs;
        logic sd;
        logic lc;
        int   ncyc;
        int   exp_ticks;
        int   exp_last;
        int   exp_level;
    } seg_t;

    seg_t tbl[$];

    function automatic seg_t mk(input logic r, input logic p, input logic rs,
                                input logic sd, input logic lc, input int n,
                                input int et, input int el, input int lv);
        seg_t s;
        s.rst_n = r; s.pz = p; s.rs = rs; s.sd = sd; s.lc = lc;
        s.ncyc = n; s.exp_ticks = et; s.exp_last = el; s.exp_level = lv;
        return s;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    // Drive inputs, let one rising edge pass, sample 1 time unit later.
    task automatic step(input logic r, input logic p, input logic rs,
                        input logic sd, input logic lc);
        reset = r; pause = p; restart = rs; soft_drop = sd; line_clr = lc;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic r, input logic p, input logic rs,
                       input logic sd, input logic lc, input int n,
                       output int ticks, output int last);
        ticks = 0;
        last  = 0;
        for (int i = 0; i < n; i++) begin
            step(r, p, rs, sd, lc);
            if (tick) ticks++;
            last = int'(tick);
        end
    endtask

    initial begin
        int t;
        int l;

        reset = 1'b0; pause = 1'b0; restart = 1'b0;
        soft_drop = 1'b0; line_clr = 1'b0;

        // Reset, first-tick latency and steady level-0 spacing.
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, t, l);
        chk("rst_tick", int'(tick), 0);
        chk("rst_level", int'(level), 0);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15, t, l);
        chk("first_gap", t, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("first_tick", int'(tick), 1);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15, t, l);
        chk("second_gap", t, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("second_tick", int'(tick), 1);
        chk("lvl0_hold", int'(level), 0);

        //            rst   pz    rs    sd    lc   n  ticks last lvl
        // levels 1..3, clamp at MIN_PERIOD
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1,  2, 0, 0, 1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  6, 1, 1, 1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16, 2, 1, 1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1,  2, 0, 0, 2));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  2, 1, 1, 2));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  8, 2, 1, 2));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1,  2, 0, 0, 3));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  2, 1, 1, 3));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  8, 2, 1, 3));
        // level saturation with ticks coinciding with line clears
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20, 5, 1, 7));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  8, 2, 1, 7));
        // reset from level 7 restores full period
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1, 1, 1, 0));
        // soft drop from cnt=9 fires next edge, then every 2
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  9, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  1, 1, 1, 0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  4, 2, 1, 0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1, 1, 1, 0));
        // pause at cnt=5 for 10 cycles, tick 11 edges after release
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  5, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1, 1, 1, 0));
        // restart on the terminal edge suppresses the tick
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0,  1, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1, 1, 1, 0));
        // climb to level 3 (period shortens below cnt), then reset mid-run
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1,  6, 1, 0, 3));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  2, 0, 0, 3));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16, 1, 1, 0));

        foreach (tbl[i]) begin
            run(tbl[i].rst_n, tbl[i].pz, tbl[i].rs, tbl[i].sd, tbl[i].lc,
                tbl[i].ncyc, t, l);
            chk($sformatf("seg%0d_ticks", i), t, tbl[i].exp_ticks);
            chk($sformatf("seg%0d_last", i), l, tbl[i].exp_last);
            chk($sformatf("seg%0d_level", i), int'(level), tbl[i].exp_level);
        end

        // Restart beats pause: counter restarts from 0 afterwards.
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7, t, l);
        chk("pre_rp_ticks", t, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rp_tick", int'(tick), 0);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15, t, l);
        chk("rp_gap", t, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rp_tick_after", int'(tick), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("one_cycle_tick", int'(tick), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
